tap_trig: RTL and testbench

- Downstream consumer of the TAP control word (`ctl`) produced by the TAP command executor.
- Compares a 14-bit unsigned ADC sample stream against the programmed threshold using the enabled GT/ET/LT conditions.
- Emits a one-cycle trigger on each rising edge of the match condition, then enforces a holdoff before re-arming.
- Keeps a saturating trigger counter and captures the triggering sample for readout.

---
 rtl/tap_trig_pkg.sv | 24 ++
 rtl/tap_cmp.sv | 15 +
 rtl/tap_trig.sv | 122 ++++++++++++
 tb/tb_tap_trig.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/tap_trig_pkg.sv
// Shared TAP trigger definitions: control-word layout and FSM state encodings.
package tap_trig_pkg;

  localparam int N_TAP_CTL_SIZE   = 18;
  localparam int CTL_TAP_THR_BITS = 14;

  // Bit layout of ctl, MSB first: trig_en, lt, et, gt, thr[13:0]
  typedef struct packed {
    logic                        trig_en;
    logic                        lt;
    logic                        et;
    logic                        gt;
    logic [CTL_TAP_THR_BITS-1:0] thr;
  } tap_ctl_t;

  localparam tap_ctl_t CTL_TAP_INIT = '0;

  typedef enum logic [1:0] {
    S_TAP_DISARMED = 2'd0,
    S_TAP_ARMED    = 2'd1,
    S_TAP_HOLDOFF  = 2'd2
  } tap_state_t;

endpackage

// File: rtl/tap_cmp.sv
// Three-way unsigned threshold comparator; any enabled condition that holds raises hit.
module tap_cmp #(
  parameter int W = 14
) (
  input  logic         gt,
  input  logic         et,
  input  logic         lt,
  input  logic [W-1:0] data,
  input  logic [W-1:0] thr,
  output logic         hit
);

  assign hit = (gt & (data > thr)) | (et & (data == thr)) | (lt & (data < thr));

endmodule

// File: rtl/tap_trig.sv
// Threshold trigger on an ADC stream: edge-detected match, holdoff FSM,
// saturating trigger counter and capture of the triggering sample.
module tap_trig
  import tap_trig_pkg::*;
#(
  parameter int P_ADC_BITS = 14,
  parameter int P_HOLDOFF  = 16,
  parameter int P_CNT_BITS = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [N_TAP_CTL_SIZE-1:0] ctl,
  input  logic                      adc_valid,
  input  logic [P_ADC_BITS-1:0]     adc_data,
  input  logic                      cnt_clr,
  output logic                      trig,
  output logic [P_ADC_BITS-1:0]     trig_sample,
  output logic [P_CNT_BITS-1:0]     trig_cnt,
  output logic                      armed
);

  localparam int HO_W = 16;
  localparam logic [HO_W-1:0] HO_LOAD = HO_W'(P_HOLDOFF - 1);

  tap_ctl_t              c;
  tap_state_t            state_q;
  tap_state_t            state_d;
  logic                  s1_valid;
  logic [P_ADC_BITS-1:0] s1_data;
  logic                  hit;
  logic                  prev_hit;
  logic                  rise;
  logic                  fire;
  logic                  force_prev;
  logic [HO_W-1:0]       ho_cnt;

  assign c = tap_ctl_t'(ctl);

  // Stage 1: register the incoming sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= adc_valid;
      s1_data  <= adc_data;
    end
  end

  // Stage 2: live threshold compare and rising-edge detect
  tap_cmp #(.W(P_ADC_BITS)) u_cmp (
    .gt   (c.gt),
    .et   (c.et),
    .lt   (c.lt),
    .data (s1_data),
    .thr  (c.thr),
    .hit  (hit)
  );

  assign rise = s1_valid & hit & ~prev_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_TAP_DISARMED;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!c.trig_en) begin
      state_d = S_TAP_DISARMED;
    end else begin
      unique case (state_q)
        S_TAP_DISARMED: state_d = S_TAP_ARMED;
        S_TAP_ARMED:    if (rise) state_d = S_TAP_HOLDOFF;
        S_TAP_HOLDOFF:  if (ho_cnt == '0) state_d = S_TAP_ARMED;
        default:        state_d = S_TAP_DISARMED;
      endcase
    end
  end

  // Arming forces prev_hit so a level already above threshold cannot fire
  always_comb begin
    armed      = 1'b0;
    fire       = 1'b0;
    force_prev = 1'b0;
    unique case (state_q)
      S_TAP_DISARMED: force_prev = c.trig_en;
      S_TAP_ARMED: begin
        armed = 1'b1;
        fire  = c.trig_en & rise;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_hit <= 1'b0;
      ho_cnt   <= '0;
    end else begin
      if (force_prev)    prev_hit <= 1'b1;
      else if (s1_valid) prev_hit <= hit;
      if (fire)                                             ho_cnt <= HO_LOAD;
      else if (state_q == S_TAP_HOLDOFF && ho_cnt != '0)    ho_cnt <= ho_cnt - 1'b1;
    end
  end

  // Stage 3: trigger pulse, sample capture and saturating count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      trig        <= 1'b0;
      trig_sample <= '0;
      trig_cnt    <= '0;
    end else begin
      trig <= fire;
      if (fire) trig_sample <= s1_data;
      if (cnt_clr)                        trig_cnt <= P_CNT_BITS'(fire);
      else if (fire && trig_cnt != '1)    trig_cnt <= trig_cnt + P_CNT_BITS'(1);
    end
  end

endmodule

// File: tb/tb_tap_trig.sv
// Directed bench for tap_trig: instance a (holdoff 16, 32-bit count), instance b (holdoff 2, 4-bit count).
module tb_tap_trig;
  import tap_trig_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  tap_ctl_t    a_ctl, b_ctl;
  logic        a_valid, b_valid, a_clr, b_clr;
  logic [13:0] a_data, b_data;
  logic        a_trig, b_trig, a_armed, b_armed;
  logic [13:0] a_sample, b_sample;
  logic [31:0] a_cnt;
  logic [3:0]  b_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  tap_trig #(.P_ADC_BITS(14), .P_HOLDOFF(16), .P_CNT_BITS(32)) dut_a (
    .clk(clk), .rst_n(rst_n), .ctl(a_ctl), .adc_valid(a_valid), .adc_data(a_data),
    .cnt_clr(a_clr), .trig(a_trig), .trig_sample(a_sample), .trig_cnt(a_cnt), .armed(a_armed)
  );

  tap_trig #(.P_ADC_BITS(14), .P_HOLDOFF(2), .P_CNT_BITS(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .ctl(b_ctl), .adc_valid(b_valid), .adc_data(b_data),
    .cnt_clr(b_clr), .trig(b_trig), .trig_sample(b_sample), .trig_cnt(b_cnt), .armed(b_armed)
  );

  function automatic tap_ctl_t mk(input logic en, input logic lt, input logic et,
                                  input logic gt, input logic [13:0] thr);
    tap_ctl_t r;
    r.trig_en = en;
    r.lt      = lt;
    r.et      = et;
    r.gt      = gt;
    r.thr     = thr;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  initial begin
    int n;
    rst_n   = 1'b1;
    a_ctl   = CTL_TAP_INIT;
    b_ctl   = CTL_TAP_INIT;
    a_valid = 1'b0; b_valid = 1'b0;
    a_clr   = 1'b0; b_clr   = 1'b0;
    a_data  = '0;   b_data  = '0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_trig", {31'd0, a_trig}, 0);
    chk("rst_sample", {18'd0, a_sample}, 0);
    chk("rst_cnt", a_cnt, 0);
    chk("rst_armed", {31'd0, a_armed}, 0);
    chk("rst_b_cnt", {28'd0, b_cnt}, 0);
    tick();
    tick();
    rst_n = 1'b1;

    // b: et|lt around 200, holdoff 2; second edge lands after holdoff expires
    b_ctl = mk(1'b1, 1'b1, 1'b1, 1'b0, 14'd200);
    b_valid = 1'b1;
    b_data = 14'd300; tick();
    b_data = 14'd200; tick();
    b_data = 14'd300; tick();
    chk("b_trig1", {31'd0, b_trig}, 1);
    chk("b_sample1", {18'd0, b_sample}, 200);
    chk("b_cnt1", {28'd0, b_cnt}, 1);
    b_valid = 1'b0; tick();
    chk("b_trig_gap", {31'd0, b_trig}, 0);
    b_valid = 1'b1; b_data = 14'd100; tick();
    b_valid = 1'b0; tick();
    chk("b_trig2", {31'd0, b_trig}, 1);
    chk("b_sample2", {18'd0, b_sample}, 100);
    chk("b_cnt2", {28'd0, b_cnt}, 2);

    // b: 21 triggers into a 4-bit counter must stop at 15
    b_ctl.trig_en = 1'b0; tick(); tick();
    b_clr = 1'b1; tick();
    b_clr = 1'b0;
    chk("b_clr", {28'd0, b_cnt}, 0);
    b_ctl.trig_en = 1'b1;
    b_valid = 1'b1;
    for (int k = 0; k < 84; k++) begin
      b_data = (k % 2 == 0) ? 14'd300 : 14'd100;
      tick();
      n = (k >= 2) ? ((k - 2) / 4 + 1) : 0;
      if (n > 15) n = 15;
      chk("b_sat_trig", {31'd0, b_trig}, (k >= 2 && k % 4 == 2) ? 32'd1 : 32'd0);
      chk("b_sat_cnt", {28'd0, b_cnt}, n);
    end
    b_ctl.trig_en = 1'b0;
    b_valid = 1'b0;

    // a: basic gt crossing of 100
    a_ctl = mk(1'b1, 1'b0, 1'b0, 1'b1, 14'd100);
    a_valid = 1'b1;
    a_data = 14'd50; tick();
    chk("a_armed", {31'd0, a_armed}, 1);
    a_data = 14'd50;  tick();
    a_data = 14'd150; tick();
    chk("a_pre", {31'd0, a_trig}, 0);
    a_data = 14'd150; tick();
    chk("a_trig", {31'd0, a_trig}, 1);
    chk("a_sample", {18'd0, a_sample}, 150);
    chk("a_cnt", a_cnt, 1);
    chk("a_hold_armed", {31'd0, a_armed}, 0);
    a_data = 14'd50; tick();
    chk("a_pulse_end", {31'd0, a_trig}, 0);
    a_ctl.trig_en = 1'b0; a_valid = 1'b0; tick(); tick();

    // a: alternating 0/20 against gt 10, holdoff 16
    a_ctl = mk(1'b1, 1'b0, 1'b0, 1'b1, 14'd10);
    a_valid = 1'b1;
    for (int k = 0; k < 40; k++) begin
      a_data = (k % 2 == 1) ? 14'd20 : 14'd0;
      tick();
      chk("alt_trig", {31'd0, a_trig}, (k >= 2 && k % 18 == 2) ? 32'd1 : 32'd0);
      chk("alt_armed", {31'd0, a_armed}, (k % 18 < 2) ? 32'd1 : 32'd0);
    end
    chk("alt_cnt", a_cnt, 4);
    a_ctl.trig_en = 1'b0; a_valid = 1'b0; tick(); tick();

    // a: enabling while the level is already high must not fire
    a_ctl = mk(1'b0, 1'b0, 1'b0, 1'b1, 14'd100);
    a_valid = 1'b1;
    a_data = 14'd500; tick(); tick(); tick();
    chk("en_dis_armed", {31'd0, a_armed}, 0);
    a_ctl.trig_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("en_high_trig", {31'd0, a_trig}, 0);
    end
    chk("en_high_armed", {31'd0, a_armed}, 1);
    a_data = 14'd0;   tick();
    a_data = 14'd500; tick();
    tick();
    chk("en_edge_trig", {31'd0, a_trig}, 1);
    chk("en_edge_cnt", a_cnt, 5);
    chk("en_edge_sample", {18'd0, a_sample}, 500);

    // a: drop trig_en three cycles into holdoff
    a_data = 14'd0; tick();
    chk("ho_trig_end", {31'd0, a_trig}, 0);
    tick();
    a_ctl.trig_en = 1'b0;
    tick();
    chk("dis_armed", {31'd0, a_armed}, 0);
    for (int k = 0; k < 20; k++) begin
      a_data = (k % 2 == 0) ? 14'd500 : 14'd0;
      tick();
      chk("dis_trig", {31'd0, a_trig}, 0);
      chk("dis_armed_hold", {31'd0, a_armed}, 0);
    end

    // a: no condition enabled never matches
    a_ctl = mk(1'b1, 1'b0, 1'b0, 1'b0, 14'd100);
    for (int k = 0; k < 8; k++) begin
      a_data = (k % 2 == 0) ? 14'd500 : 14'd0;
      tick();
      chk("nocond_trig", {31'd0, a_trig}, 0);
    end
    chk("nocond_cnt", a_cnt, 5);

    // a: clear coinciding with a trigger, then reset mid-holdoff
    a_ctl = mk(1'b1, 1'b0, 1'b0, 1'b1, 14'd100);
    a_data = 14'd0;   tick();
    a_data = 14'd500; tick();
    a_clr = 1'b1;     tick();
    a_clr = 1'b0;
    chk("clr_trig", {31'd0, a_trig}, 1);
    chk("clr_cnt", a_cnt, 1);
    tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_trig", {31'd0, a_trig}, 0);
    chk("mid_rst_sample", {18'd0, a_sample}, 0);
    chk("mid_rst_cnt", a_cnt, 0);
    chk("mid_rst_armed", {31'd0, a_armed}, 0);
    chk("mid_rst_b_cnt", {28'd0, b_cnt}, 0);
    tick();
    chk("in_rst_armed", {31'd0, a_armed}, 0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_armed", {31'd0, a_armed}, 0);
    tick();
    chk("rearm_armed", {31'd0, a_armed}, 1);
    tick();
    chk("rearm_no_trig", {31'd0, a_trig}, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
